muxer16_rr_sched: RTL and testbench
===================================

// Module: muxer16_rr_sched
// PURPOSE
//  Round-robin scheduler that shares one 16:1 single-bit mux (muxer16) among 16 requesters.
//  Picks a requester, drives the mux select, samples the mux output and presents it as one
//  registered valid/ready transfer tagged with the source index.
//  Sits between the requester bank and the downstream single-bit consumer; muxer16 is instantiated
//  outside this block and wired via sel/mux_q.
// PARAMETERS
//  N     16            number of requesters / mux inputs (power of 2, >= 2)
//  SELW  $clog2(N)     select / source-index width (4 at default)
// PORTS
//  clk        in   1     clock, all state on rising edge
//  rst        in   1     asynchronous reset, active-high
//  req        in   N     req[i]=1: requester i wants its bit read; level, held until gnt[i]
//  sel        out  SELW  select to muxer16; registered
//  mux_q      in   1     muxer16 output q (combinational from sel and in)
//  gnt        out  N     one-hot, 1-cycle acknowledge to the winning requester
//  out_valid  out  1     out_data/out_src hold a transfer
//  out_ready  in   1     downstream accepts the transfer when out_valid && out_ready
//  out_data   out  1     sampled mux_q
//  out_src    out  SELW  index of requester whose bit is in out_data
// BEHAVIOUR
//  Reset (async, rst=1): state=IDLE, sel=0, ptr=0, gnt=0, out_valid=0, out_data=0, out_src=0.
//  FSM states: IDLE, SAMPLE, HOLD.
//   IDLE: if |req: winner = first i with req[i]=1, searching ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
//         sel<=winner, goto SAMPLE. If req==0: stay, sel holds its value.
//   SAMPLE: out_data<=mux_q, out_src<=sel, out_valid<=1, gnt[sel]=1 for this cycle only, goto HOLD.
//   HOLD: out_valid=1; data/src stable. On out_ready=1: out_valid<=0, ptr<=(out_src+1) mod N
//         (N-1 wraps to 0), goto IDLE. On out_ready=0: stay in HOLD.
//  Latency: req seen in IDLE at edge k -> sel valid after k -> out_valid=1 after k+1.
//   Minimum 3 cycles per transfer (IDLE, SAMPLE, HOLD with out_ready=1).
//  gnt is combinational from state==SAMPLE and sel. It is one-hot and never asserted outside SAMPLE.
//  sel changes only on the IDLE->SAMPLE transition. It is stable through SAMPLE and HOLD.
//  Winner is locked at IDLE: req[winner] dropping in SAMPLE does not abort; the bit is still sampled.
//  New/changed req bits during SAMPLE/HOLD take effect at the next IDLE arbitration only.
//  out_ready while out_valid=0 is ignored.
//  Fairness: a continuously asserting requester waits at most N-1 transfers.
//  Reset asserted mid-SAMPLE/HOLD: the transfer is discarded and all outputs take their reset values immediately.
//  in/mux_q X-free assumed valid one cycle after sel update (mux combinational, no extra settle).
// TESTING
//  1 Reset: rst=1 mid-HOLD with out_valid=1 -> out_valid=0, sel=0, gnt=0 same cycle; IDLE after release.
//  2 Single req: req=16'h0020, in[5]=1, out_ready=1 -> sel=5, gnt=16'h0020 one cycle,
//    out_valid=1 with out_data=1, out_src=5 two cycles after req; repeat with in[5]=0 -> out_data=0.
//  3 Round-robin: req=16'hFFFF held, out_ready=1, in=16'hAAAA -> out_src sequence 0,1,2,...,15,0
//    with out_data alternating 0,1; one transfer every 3 cycles.
//  4 Wrap/priority: ptr=15 after grant to 14, req=16'h8001 -> grant 15 then 0; with req=16'h0003
//    after grant 0 -> grant 1 then 0.
//  5 Backpressure: out_ready=0 for 5 cycles during HOLD, in toggled -> out_valid, out_data, out_src, sel
//    stable; no gnt; single transfer completes when out_ready=1.
//  6 Req drop: req[3] deasserted in SAMPLE cycle -> transfer for src 3 still delivered; next IDLE skips 3.

Source files
------------

// File: rtl/muxer16_rr_sched.sv
// muxer16_rr_sched: round-robin owner of one shared N:1 single-bit mux.
// Picks a requester, samples its bit and hands it off valid/ready.
module muxer16_rr_sched #(
  parameter int N    = 16,
  parameter int SELW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  output logic [SELW-1:0] sel,
  input  logic            mux_q,
  output logic [N-1:0]    gnt,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_data,
  output logic [SELW-1:0] out_src
);

  typedef enum logic [1:0] {
    IDLE,
    SAMPLE,
    HOLD
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic [SELW-1:0] ptr;
  logic [SELW-1:0] win;
  logic            any_req;

  assign any_req = |req;

  // rotating priority search: lowest offset from ptr wins
  always_comb begin
    win = ptr;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[ptr + SELW'(k)]) begin
        win = ptr + SELW'(k);
      end
    end
  end

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // next-state: arbitrate, sample for one cycle, hold until taken
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (any_req) begin
          state_nx = SAMPLE;
        end
      end
      SAMPLE: begin
        state_nx = HOLD;
      end
      HOLD: begin
        if (out_ready) begin
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // one-hot acknowledge, only while the bit is being sampled
  always_comb begin
    gnt = '0;
    if (state == SAMPLE) begin
      gnt[sel] = 1'b1;
    end
  end

  // select, pointer and output transfer registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel       <= '0;
      ptr       <= '0;
      out_valid <= 1'b0;
      out_data  <= 1'b0;
      out_src   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (any_req) begin
            sel <= win;
          end
        end
        SAMPLE: begin
          out_data  <= mux_q;
          out_src   <= sel;
          out_valid <= 1'b1;
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            ptr       <= out_src + SELW'(1);
          end
        end
        default: begin
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muxer16_rr_sched.sv
// tb_muxer16_rr_sched: scoreboard bench for the round-robin mux scheduler.
// A behavioural 16:1 mux feeds mux_q from in_bits and the DUT's sel.
module tb_muxer16_rr_sched;

  logic        clk;
  logic        rst;
  logic [15:0] req;
  logic [3:0]  sel;
  logic        mux_q;
  logic [15:0] gnt;
  logic        out_valid;
  logic        out_ready;
  logic        out_data;
  logic [3:0]  out_src;
  logic [15:0] in_bits;

  typedef struct packed {
    logic [3:0] src;
    logic       data;
  } exp_t;

  exp_t     sbq[$];
  logic [3:0] mptr;
  bit       auto_clr;
  int       total;
  int       bad;
  int       cyc;

  assign mux_q = in_bits[sel];

  muxer16_rr_sched dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .sel       (sel),
    .mux_q     (mux_q),
    .gnt       (gnt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_src   (out_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] rr_pick(input logic [15:0] r,
                                         input logic [3:0] p);
    logic [3:0] idx;
    for (int k = 0; k < 16; k++) begin
      idx = p + 4'(k);
      if (r[idx]) return idx;
    end
    return p;
  endfunction

  task automatic push_exp(input logic [3:0] s);
    exp_t e;
    e.src  = s;
    e.data = in_bits[s];
    sbq.push_back(e);
    mptr = s + 4'd1;
  endtask

  // pops/compares on a handshake, then advances one cycle
  task automatic tick();
    exp_t e;
    if (out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        chk("sb_extra", {28'd0, out_src}, 32'hFFFF_FFFF);
      end else begin
        e = sbq.pop_front();
        chk("sb_src", 32'(out_src), 32'(e.src));
        chk("sb_data", 32'(out_data), 32'(e.data));
      end
    end
    @(posedge clk);
    #1;
    chk("gnt_1hot", 32'($onehot0(gnt)), 32'd1);
    if (auto_clr) req = req & ~gnt;
  endtask

  task automatic drain(input int budget, output int n);
    n = 0;
    while ((sbq.size() != 0 || out_valid) && n < budget) begin
      tick();
      n++;
    end
    if (sbq.size() != 0 || out_valid) begin
      chk("drain_to", 32'(sbq.size()) + 32'(out_valid), 32'd0);
    end
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    #1;
    sbq.delete();
    mptr = 4'd0;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst       = 1'b1;
    req       = '0;
    out_ready = 1'b0;
    in_bits   = '0;
    auto_clr  = 1'b1;
    mptr      = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_sel", 32'(sel), 32'd0);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_src", 32'(out_src), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    rst = 1'b0;
    tick();

    // reset in the middle of HOLD discards the transfer
    in_bits = 16'h0100;
    req     = 16'h0100;
    push_exp(4'd8);
    tick();
    tick();
    chk("t1_hold_valid", 32'(out_valid), 32'd1);
    chk("t1_hold_sel", 32'(sel), 32'd8);
    rst = 1'b1;
    #1;
    chk("t1_rst_valid", 32'(out_valid), 32'd0);
    chk("t1_rst_sel", 32'(sel), 32'd0);
    chk("t1_rst_gnt", 32'(gnt), 32'd0);
    sbq.delete();
    mptr = 4'd0;
    tick();
    rst = 1'b0;
    tick();
    chk("t1_idle_valid", 32'(out_valid), 32'd0);
    chk("t1_idle_gnt", 32'(gnt), 32'd0);

    // single requester, data 1 then data 0
    out_ready = 1'b1;
    in_bits   = 16'h0020;
    req       = 16'h0020;
    push_exp(4'd5);
    tick();
    chk("t2_sel", 32'(sel), 32'd5);
    chk("t2_gnt", 32'(gnt), 32'h0020);
    chk("t2_valid0", 32'(out_valid), 32'd0);
    tick();
    chk("t2_gnt_off", 32'(gnt), 32'd0);
    chk("t2_valid1", 32'(out_valid), 32'd1);
    chk("t2_data", 32'(out_data), 32'd1);
    chk("t2_src", 32'(out_src), 32'd5);
    drain(10, cyc);
    in_bits = 16'h0000;
    req     = 16'h0020;
    push_exp(4'd5);
    tick();
    tick();
    chk("t2_data0", 32'(out_data), 32'd0);
    drain(10, cyc);

    // all requesters held: 0..15,0 with alternating data
    pulse_rst();
    auto_clr = 1'b0;
    in_bits  = 16'hAAAA;
    req      = 16'hFFFF;
    for (int i = 0; i < 17; i++) begin
      push_exp(rr_pick(req, mptr));
    end
    drain(80, cyc);
    req = '0;
    chk("t3_cycles", 32'(cyc), 32'd51);
    auto_clr = 1'b1;

    // wrap: 14, then 15 and 0; then 1 and 0
    in_bits = 16'hC003;
    req     = 16'h4000;
    push_exp(4'd14);
    drain(10, cyc);
    req = 16'h8001;
    push_exp(4'd15);
    push_exp(4'd0);
    drain(20, cyc);
    req = 16'h0003;
    push_exp(4'd1);
    push_exp(4'd0);
    drain(20, cyc);

    // backpressure: everything stable while out_ready is low
    out_ready = 1'b0;
    in_bits   = 16'h0200;
    req       = 16'h0200;
    push_exp(4'd9);
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      in_bits = ~in_bits;
      tick();
      chk("t5_valid", 32'(out_valid), 32'd1);
      chk("t5_data", 32'(out_data), 32'd1);
      chk("t5_src", 32'(out_src), 32'd9);
      chk("t5_sel", 32'(sel), 32'd9);
      chk("t5_gnt", 32'(gnt), 32'd0);
    end
    out_ready = 1'b1;
    drain(10, cyc);
    chk("t5_done", 32'(out_valid), 32'd0);

    // requester 3 drops in SAMPLE; next arbitration goes to 4
    in_bits = 16'h0008;
    req     = 16'h0018;
    push_exp(4'd3);
    push_exp(4'd4);
    tick();
    chk("t6_gnt", 32'(gnt), 32'h0008);
    chk("t6_req", 32'(req), 32'h0010);
    drain(20, cyc);
    chk("t6_empty", 32'(sbq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
